// File: rtl/demux4_pkg.sv
// Shared types and channel constants for the 1-to-4 stream demultiplexer.
package demux4_pkg;
  typedef logic [1:0] chan_sel_t;

  localparam chan_sel_t CH0 = 2'd0;
  localparam chan_sel_t CH1 = 2'd1;
  localparam chan_sel_t CH2 = 2'd2;
  localparam chan_sel_t CH3 = 2'd3;
  localparam int        NCH = 4;
endpackage

// File: rtl/demux4_slot.sv
// One-entry output register for a single demux channel.
// Optional completed-transfer counter is built when DEMUX4_CNT_EN is defined.
module demux4_slot
  import demux4_pkg::*;
#(
  parameter int N  = 4,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic          drain,
  input  logic [N-1:0]  din,
  output logic [N-1:0]  q,
  output logic          valid,
  output logic          ready_up,
  output logic [CW-1:0] cnt
);

  // A draining slot can take a new word in the same cycle, so no bubble.
  assign ready_up = ~valid | drain;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q     <= '0;
      valid <= 1'b0;
    end else if (load) begin
      q     <= din;
      valid <= 1'b1;
    end else if (drain) begin
      valid <= 1'b0;
    end
  end

`ifdef DEMUX4_CNT_EN
  logic hs;
  assign hs = valid & drain;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)   cnt <= '0;
    else if (hs) cnt <= cnt + 1'b1;
  end
`else
  assign cnt = '0;
`endif

endmodule

// File: rtl/demux4_stream.sv
// 1-to-4 stream demultiplexer: steers each accepted word to the channel tagged by s.
// Per-channel transfer counters are enabled with DEMUX4_CNT_EN.
module demux4_stream
  import demux4_pkg::*;
#(
  parameter int N  = 4,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  d,
  input  logic [1:0]    s,
  output logic [N-1:0]  y0,
  output logic [N-1:0]  y1,
  output logic [N-1:0]  y2,
  output logic [N-1:0]  y3,
  output logic          v0,
  output logic          v1,
  output logic          v2,
  output logic          v3,
  input  logic          r0,
  input  logic          r1,
  input  logic          r2,
  input  logic          r3,
  output logic [CW-1:0] cnt0,
  output logic [CW-1:0] cnt1,
  output logic [CW-1:0] cnt2,
  output logic [CW-1:0] cnt3
);

  chan_sel_t                   sel;
  logic [NCH-1:0]              ld, rdy, vld, rr;
  logic [NCH-1:0][N-1:0]       yq;
  logic [NCH-1:0][CW-1:0]      cq;

  assign sel      = s;
  assign rr       = {r3, r2, r1, r0};
  // Only the addressed channel gates acceptance; r->in_ready is combinational.
  assign in_ready = rdy[sel];

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    assign ld[i] = in_valid & in_ready & (sel == chan_sel_t'(i));

    demux4_slot #(.N(N), .CW(CW)) u_slot (
      .clk      (clk),
      .reset    (reset),
      .load     (ld[i]),
      .drain    (rr[i]),
      .din      (d),
      .q        (yq[i]),
      .valid    (vld[i]),
      .ready_up (rdy[i]),
      .cnt      (cq[i])
    );
  end

  assign y0 = yq[CH0];
  assign y1 = yq[CH1];
  assign y2 = yq[CH2];
  assign y3 = yq[CH3];

  assign v0 = vld[CH0];
  assign v1 = vld[CH1];
  assign v2 = vld[CH2];
  assign v3 = vld[CH3];

  assign cnt0 = cq[CH0];
  assign cnt1 = cq[CH1];
  assign cnt2 = cq[CH2];
  assign cnt3 = cq[CH3];

endmodule

// File: tb/tb_demux4_stream.sv
// Directed self-checking bench for demux4_stream (N=4, CW=8).
module tb_demux4_stream;
  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid, in_ready;
  logic [3:0] d;
  logic [1:0] s;
  logic [3:0] y0, y1, y2, y3;
  logic       v0, v1, v2, v3;
  logic       r0, r1, r2, r3;
  logic [7:0] cnt0, cnt1, cnt2, cnt3;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  demux4_stream #(.N(4), .CW(8)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .d(d), .s(s),
    .y0(y0), .y1(y1), .y2(y2), .y3(y3),
    .v0(v0), .v1(v1), .v2(v2), .v3(v3),
    .r0(r0), .r1(r1), .r2(r2), .r3(r3),
    .cnt0(cnt0), .cnt1(cnt1), .cnt2(cnt2), .cnt3(cnt3)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int         in_idx, out_idx, cyc, hs0;
    logic [7:0] exp_cnt0;

    reset = 1'b1; in_valid = 1'b0; d = '0; s = '0;
    {r3, r2, r1, r0} = 4'b0000;
    #12;
    chk("rst_v",   32'({v3, v2, v1, v0}), 32'h0);
    chk("rst_y",   32'({y3, y2, y1, y0}), 32'h0);
    chk("rst_cnt", 32'({cnt3, cnt2, cnt1, cnt0}), 32'h0);
    reset = 1'b0;
    step();

    // 1. reset mid-stream with ch2 holding A
    in_valid = 1'b1; d = 4'hA; s = 2'd2;
    step();
    in_valid = 1'b0;
    chk("t1_v2", 32'(v2), 32'd1);
    chk("t1_y2", 32'(y2), 32'hA);
    #2 reset = 1'b1;
    #1;
    chk("t1_rst_v",   32'({v3, v2, v1, v0}), 32'h0);
    chk("t1_rst_y",   32'({y3, y2, y1, y0}), 32'h0);
    chk("t1_rst_cnt", 32'({cnt3, cnt2, cnt1, cnt0}), 32'h0);
    #3 reset = 1'b0;
    step();

    // 2. route sweep, all consumers ready
    {r3, r2, r1, r0} = 4'b1111;
    in_valid = 1'b1;
    d = 4'd1; s = 2'd0; #1 chk("t2_rdy0", 32'(in_ready), 32'd1);
    step();
    chk("t2_v0", 32'(v0), 32'd1); chk("t2_y0", 32'(y0), 32'd1);
    d = 4'd2; s = 2'd1; #1 chk("t2_rdy1", 32'(in_ready), 32'd1);
    step();
    chk("t2_v1", 32'({v1, v0}), 32'b10); chk("t2_y1", 32'(y1), 32'd2);
    d = 4'd3; s = 2'd2; #1 chk("t2_rdy2", 32'(in_ready), 32'd1);
    step();
    chk("t2_v2", 32'({v2, v1}), 32'b10); chk("t2_y2", 32'(y2), 32'd3);
    d = 4'd4; s = 2'd3; #1 chk("t2_rdy3", 32'(in_ready), 32'd1);
    step();
    chk("t2_v3", 32'({v3, v2}), 32'b10); chk("t2_y3", 32'(y3), 32'd4);
    in_valid = 1'b0;
    step();
    chk("t2_drained", 32'({v3, v2, v1, v0}), 32'h0);

    // 3. stall isolation on ch1
    r1 = 1'b0;
    in_valid = 1'b1; d = 4'h5; s = 2'd1;
    step();
    chk("t3_v1", 32'(v1), 32'd1); chk("t3_y1", 32'(y1), 32'h5);
    d = 4'h6; s = 2'd1; #1 chk("t3_blocked", 32'(in_ready), 32'd0);
    step();
    chk("t3_y1_hold", 32'(y1), 32'h5);
    d = 4'h7; s = 2'd3; #1 chk("t3_rdy3", 32'(in_ready), 32'd1);
    step();
    chk("t3_y3", 32'(y3), 32'h7); chk("t3_v3", 32'(v3), 32'd1);
    chk("t3_y1_hold2", 32'({v1, y1}), 32'h15);

    // 4. same-cycle reload on ch0
    r0 = 1'b0; d = 4'h8; s = 2'd0;
    step();
    chk("t4_y0", 32'({v0, y0}), 32'h18);
    r0 = 1'b1; d = 4'h9; s = 2'd0; #1 chk("t4_rdy", 32'(in_ready), 32'd1);
    step();
    chk("t4_reload", 32'({v0, y0}), 32'h19);
    in_valid = 1'b0;
    step();
    chk("t4_drain", 32'(v0), 32'd0);

    // 5. ch2 receives 1..10 while r2 toggles
    in_idx = 0; out_idx = 0; cyc = 0;
    s = 2'd2;
    while (out_idx < 10 && cyc < 100) begin
      r2 = cyc[0] ? 1'b0 : 1'b1;
      in_valid = (in_idx < 10);
      d = 4'(in_idx + 1);
      #1;
      if (v2 && r2) begin
        chk("t5_order", 32'(y2), 32'(out_idx + 1));
        out_idx++;
      end
      if (in_valid && in_ready) in_idx++;
      step();
      cyc++;
    end
    in_valid = 1'b0;
    chk("t5_count", 32'(out_idx), 32'd10);
    r2 = 1'b1;
    step();

    // 6. 257 handshakes on ch0 from a fresh reset
    #2 reset = 1'b1;
    #2 reset = 1'b0;
    step();
    {r3, r2, r1, r0} = 4'b0001;
    in_valid = 1'b1; s = 2'd0; hs0 = 0; cyc = 0;
    while (hs0 < 257 && cyc < 1000) begin
      in_valid = (cyc < 257);
      d = 4'(cyc);
      #1;
      if (v0 && r0) hs0++;
      step();
      cyc++;
    end
    in_valid = 1'b0;
    chk("t6_hs", 32'(hs0), 32'd257);
`ifdef DEMUX4_CNT_EN
    exp_cnt0 = 8'd1;
`else
    exp_cnt0 = 8'd0;
`endif
    chk("t6_cnt0", 32'(cnt0), 32'(exp_cnt0));
    chk("t6_cnt_oth", 32'({cnt3, cnt2, cnt1}), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
